wvb_rd_addr_ctrl_mc: RTL and testbench
======================================

# wvb_rd_addr_ctrl_mc

Multi-channel, parametrised read-address controller for the mDOM waveform buffers. It owns one read pointer shared across `P_N_CHAN` circular waveform buffers. On each header read it latches the target channel, then loads the event's start/stop addresses after a configurable header-FIFO latency. It steps the address per word request, handling wrap-around, and signals last-word and completion to the readout engine. It sits between the header FIFOs (external fan-out) and the waveform buffer RAM read ports.

## Interface
Parameters:
- `P_ADR_WIDTH`, 12, waveform buffer address width; buffer depth is 2^P_ADR_WIDTH.
- `P_N_CHAN`, 4, number of waveform buffers served (≥1).
- `P_CHAN_WIDTH`, 2, width of channel index; must satisfy 2^P_CHAN_WIDTH ≥ P_N_CHAN.
- `P_HDR_WAIT`, 2, cycles from `hdr_rdreq` to valid `hdr_start_addr`/`hdr_stop_addr` (1..7).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `chan_sel`  in  P_CHAN_WIDTH  channel to read; sampled with `hdr_rdreq`.
- `hdr_rdreq`  in  1  single-cycle header pop for `chan_sel`.
- `hdr_start_addr`  in  P_ADR_WIDTH  first waveform address of the event.
- `hdr_stop_addr`  in  P_ADR_WIDTH  last waveform address of the event.
- `wvb_rdreq`  in  1  request the next word; advances the pointer.
- `wvb_rddone`  in  1  abort/finish the event early.
- `wvb_rd_addr`  out  P_ADR_WIDTH  registered read address.
- `wvb_rd_chan`  out  P_CHAN_WIDTH  latched channel index.
- `rd_active`  out  1  pointer valid for the current event.
- `rd_last`  out  1  `wvb_rd_addr` equals the latched stop address while `rd_active`.
- `rd_done`  out  1  one-cycle pulse at event completion.
- `words_left`  out  P_ADR_WIDTH+1  words remaining, including the current word.

## Operation
- The FSM has three states: IDLE, HDR_WAIT and READ.
- IDLE → HDR_WAIT on `hdr_rdreq`. This transition latches `chan_sel` into `wvb_rd_chan` (values ≥ P_N_CHAN are clamped to P_N_CHAN-1) and starts a wait counter at 1.
- HDR_WAIT counts up each cycle. When the count equals P_HDR_WAIT, the block:
  - samples the header;
  - sets `wvb_rd_addr` to start;
  - latches stop;
  - sets `words_left` = ((stop − start) mod 2^P_ADR_WIDTH) + 1;
  - moves to READ.
- READ, `wvb_rdreq`, not last: `wvb_rd_addr` +1 modulo 2^P_ADR_WIDTH (the natural wrap from all-ones to 0) and `words_left` −1.
- READ, `wvb_rdreq` while `rd_last`: `wvb_rd_addr` = stop+1 (mod), `words_left` = 0, `rd_done` pulse, → IDLE.
- READ, `wvb_rddone`: `wvb_rd_addr` = stop+1, `words_left` = 0, `rd_done` pulse, → IDLE. This takes priority over `wvb_rdreq` in the same cycle.
- The block ignores `hdr_rdreq` in HDR_WAIT and READ; the header is not consumed by this block.
- The block ignores `wvb_rdreq` and `wvb_rddone` in IDLE and HDR_WAIT.
- Length arithmetic:
  - start == stop gives a 1-word event.
  - stop == start−1 gives a full-buffer event of 2^P_ADR_WIDTH words, which is why `words_left` is 1 bit wider than the address.
- In IDLE, `wvb_rd_addr` holds its last value: stop+1 of the previous event, or all-ones after reset.

## Timing
- Reset values:
  - `wvb_rd_addr` = all-ones;
  - `wvb_rd_chan` = 0;
  - `rd_active` = 0, `rd_last` = 0, `rd_done` = 0;
  - `words_left` = 0;
  - FSM in IDLE.
- Reset mid-event returns all outputs to their reset values on the next edge.
- `hdr_rdreq` at edge t: header sampled at edge t+P_HDR_WAIT. `wvb_rd_addr`, `rd_active` and `words_left` are valid after that edge, i.e. during cycle t+P_HDR_WAIT.
- `wvb_rdreq` at edge t: the new address is visible after edge t, so the pointer update has 1-cycle latency.
- `rd_last` is combinational from registered state and has no added latency.
- `rd_done` is high for exactly the cycle after the final/abort edge. `rd_active` falls on the same edge.
- The earliest back-to-back header read is in the cycle `rd_done` is high.
- All outputs are registered except `rd_last`.

## Configuration
- Macro `WVB_RD_ADDR_OVERRUN_CHK_EN` adds:
  - output `rd_err` (1 bit, sticky until `rst`);
  - `rd_err` sets on `wvb_rdreq` outside READ;
  - `rd_err` sets on `hdr_rdreq` outside IDLE;
  - `rd_err` sets on `chan_sel` ≥ P_N_CHAN.
- Without the macro, `rd_err` is absent and those events are silently ignored or clamped as described above.

## Test plan
- Reset, then idle: `wvb_rd_addr` = 0xFFF, `rd_active` = 0, `words_left` = 0.
- `hdr_rdreq`, chan 2, start 0x010, stop 0x013, 4 rdreqs:
  - `wvb_rd_chan` = 2;
  - addresses 0x010..0x013;
  - `rd_last` on 0x013;
  - `rd_done` pulse after the 4th rdreq;
  - final address 0x014.
- Wrap: start 0xFFE, stop 0x001 → `words_left` = 4, addresses 0xFFE, 0xFFF, 0x000, 0x001, then 0x002.
- Full buffer: start 0x100, stop 0x0FF → `words_left` = 4096. After 4096 rdreqs, `rd_done` pulses and the address is 0x100.
- Abort:
  - start 0x020, stop 0x030;
  - 2 rdreqs, then `wvb_rddone` together with `wvb_rdreq`;
  - expect address 0x031, `rd_done`, and `words_left` = 0.
- With `WVB_RD_ADDR_OVERRUN_CHK_EN`, P_HDR_WAIT = 3:
  - `hdr_rdreq` during READ → `rd_err` = 1 and the event continues unaffected;
  - start address loads exactly 3 cycles after `hdr_rdreq`.

Source files
------------

// File: rtl/wvb_rd_addr_ctrl_mc.sv
// Shared read-pointer controller for P_N_CHAN circular waveform buffers.
// Optional macro WVB_RD_ADDR_OVERRUN_CHK_EN adds the sticky rd_err protocol-error flag.
module wvb_rd_addr_ctrl_mc #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_N_CHAN     = 4,
    parameter int P_CHAN_WIDTH = 2,
    parameter int P_HDR_WAIT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_CHAN_WIDTH-1:0] chan_sel,
    input  logic                    hdr_rdreq,
    input  logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
    input  logic                    wvb_rdreq,
    input  logic                    wvb_rddone,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    output logic [P_CHAN_WIDTH-1:0] wvb_rd_chan,
    output logic                    rd_active,
    output logic                    rd_last,
    output logic                    rd_done,
    output logic [P_ADR_WIDTH:0]    words_left
`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
    ,
    output logic                    rd_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR_WAIT,
        S_READ
    } state_t;

    state_t                  state;
    logic [2:0]              wait_cnt;
    logic [P_ADR_WIDTH-1:0]  stop_q;

    function automatic logic [P_CHAN_WIDTH-1:0] clamp_chan(input logic [P_CHAN_WIDTH-1:0] c);
        if (int'(c) >= P_N_CHAN)
            return P_CHAN_WIDTH'(P_N_CHAN - 1);
        return c;
    endfunction

    // Length is modular so stop == start-1 yields the full 2^P_ADR_WIDTH words.
    function automatic logic [P_ADR_WIDTH:0] event_len(input logic [P_ADR_WIDTH-1:0] start,
                                                       input logic [P_ADR_WIDTH-1:0] stop);
        logic [P_ADR_WIDTH-1:0] diff;
        diff = stop - start;
        return {1'b0, diff} + (P_ADR_WIDTH+1)'(1);
    endfunction

    assign rd_last = rd_active && (wvb_rd_addr == stop_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            wvb_rd_addr <= '1;
            wvb_rd_chan <= '0;
            rd_active   <= 1'b0;
            rd_done     <= 1'b0;
            words_left  <= '0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_rdreq) begin
                        wvb_rd_chan <= clamp_chan(chan_sel);
                        wait_cnt    <= 3'd1;
                        state       <= S_HDR_WAIT;
                    end
                end
                S_HDR_WAIT: begin
                    // Header FIFO outputs become valid P_HDR_WAIT edges after the pop.
                    if (wait_cnt == 3'(P_HDR_WAIT)) begin
                        wvb_rd_addr <= hdr_start_addr;
                        stop_q      <= hdr_stop_addr;
                        words_left  <= event_len(hdr_start_addr, hdr_stop_addr);
                        rd_active   <= 1'b1;
                        state       <= S_READ;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_READ: begin
                    if (wvb_rddone || (wvb_rdreq && rd_last)) begin
                        wvb_rd_addr <= stop_q + P_ADR_WIDTH'(1);
                        words_left  <= '0;
                        rd_done     <= 1'b1;
                        rd_active   <= 1'b0;
                        state       <= S_IDLE;
                    end else if (wvb_rdreq) begin
                        wvb_rd_addr <= wvb_rd_addr + P_ADR_WIDTH'(1);
                        words_left  <= words_left - (P_ADR_WIDTH+1)'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err <= 1'b0;
        end else if ((wvb_rdreq && state != S_READ) ||
                     (hdr_rdreq && state != S_IDLE) ||
                     (hdr_rdreq && state == S_IDLE && int'(chan_sel) >= P_N_CHAN)) begin
            rd_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wvb_rd_addr_ctrl_mc.sv
// Scoreboard bench for wvb_rd_addr_ctrl_mc: expected word tuples are queued as
// read requests are driven and compared when the DUT presents the word.
module tb_wvb_rd_addr_ctrl_mc;

    localparam int AW = 12;
    localparam int CW = 2;
    localparam int HW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] chan_sel;
    logic          hdr_rdreq;
    logic [AW-1:0] hdr_start_addr;
    logic [AW-1:0] hdr_stop_addr;
    logic          wvb_rdreq;
    logic          wvb_rddone;
    logic [AW-1:0] wvb_rd_addr;
    logic [CW-1:0] wvb_rd_chan;
    logic          rd_active;
    logic          rd_last;
    logic          rd_done;
    logic [AW:0]   words_left;
`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
    logic          rd_err;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic          last;
        logic [AW:0]   wl;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    wvb_rd_addr_ctrl_mc #(
        .P_ADR_WIDTH (AW),
        .P_N_CHAN    (4),
        .P_CHAN_WIDTH(CW),
        .P_HDR_WAIT  (HW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chan_sel      (chan_sel),
        .hdr_rdreq     (hdr_rdreq),
        .hdr_start_addr(hdr_start_addr),
        .hdr_stop_addr (hdr_stop_addr),
        .wvb_rdreq     (wvb_rdreq),
        .wvb_rddone    (wvb_rddone),
        .wvb_rd_addr   (wvb_rd_addr),
        .wvb_rd_chan   (wvb_rd_chan),
        .rd_active     (rd_active),
        .rd_last       (rd_last),
        .rd_done       (rd_done),
        .words_left    (words_left)
`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
        ,
        .rd_err        (rd_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word monitor: each accepted request is compared against the queued expectation.
    always @(negedge clk) begin
        if (!rst && wvb_rdreq && rd_active) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("word_addr", 32'(wvb_rd_addr), 32'(e.addr));
                check("word_last", 32'(rd_last), 32'(e.last));
                check("word_left", 32'(words_left), 32'(e.wl));
            end
        end
    end

    task automatic check_reset_state();
        check("rst_addr", 32'(wvb_rd_addr), 32'hFFF);
        check("rst_chan", 32'(wvb_rd_chan), 0);
        check("rst_active", 32'(rd_active), 0);
        check("rst_last", 32'(rd_last), 0);
        check("rst_done", 32'(rd_done), 0);
        check("rst_left", 32'(words_left), 0);
    endtask

    task automatic start_header(input logic [CW-1:0] ch, input logic [AW-1:0] st, input logic [AW-1:0] sp);
        int len;
        len            = int'(12'(sp - st)) + 1;
        chan_sel       = ch;
        hdr_start_addr = st;
        hdr_stop_addr  = sp;
        hdr_rdreq      = 1'b1;
        @(posedge clk); #1;
        hdr_rdreq = 1'b0;
        for (int i = 1; i < HW; i++) begin
            @(posedge clk); #1;
            check("hdr_wait_inactive", 32'(rd_active), 0);
        end
        @(posedge clk); #1;
        check("load_active", 32'(rd_active), 1);
        check("load_addr", 32'(wvb_rd_addr), 32'(st));
        check("load_left", 32'(words_left), 32'(len));
        check("load_chan", 32'(wvb_rd_chan), 32'(ch));
        check("load_done_low", 32'(rd_done), 0);
    endtask

    task automatic run_event(input logic [CW-1:0] ch, input logic [AW-1:0] st, input logic [AW-1:0] sp,
                             input int nreq, input bit abort, input bit extra_hdr);
        int len;
        exp_t e;
        len = int'(12'(sp - st)) + 1;
        start_header(ch, st, sp);
        for (int k = 0; k < nreq; k++) begin
            e.addr = 12'(st + 12'(k));
            e.last = (k == len - 1);
            e.wl   = 13'(len - k);
            sb.push_back(e);
            wvb_rdreq  = 1'b1;
            wvb_rddone = abort && (k == nreq - 1);
            if (extra_hdr && k == 1) begin
                hdr_rdreq      = 1'b1;
                chan_sel       = ~ch;
                hdr_start_addr = ~st;
            end
            @(posedge clk); #1;
            hdr_rdreq      = 1'b0;
            chan_sel       = ch;
            hdr_start_addr = st;
        end
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        if (abort || nreq == len) begin
            check("end_done", 32'(rd_done), 1);
            check("end_active", 32'(rd_active), 0);
            check("end_addr", 32'(wvb_rd_addr), 32'(12'(sp + 12'd1)));
            check("end_left", 32'(words_left), 0);
            check("end_last", 32'(rd_last), 0);
            check("end_chan", 32'(wvb_rd_chan), 32'(ch));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        chan_sel       = '0;
        hdr_rdreq      = 1'b0;
        hdr_start_addr = '0;
        hdr_stop_addr  = '0;
        wvb_rdreq      = 1'b0;
        wvb_rddone     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state();
`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
        check("err_after_rst", 32'(rd_err), 0);
`endif

        // Read requests and aborts in IDLE must not move the pointer.
        wvb_rdreq  = 1'b1;
        wvb_rddone = 1'b1;
        @(posedge clk); #1;
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        @(posedge clk); #1;
        check("idle_addr_hold", 32'(wvb_rd_addr), 32'hFFF);
        check("idle_active", 32'(rd_active), 0);
        check("idle_done", 32'(rd_done), 0);
`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
        check("err_idle_rdreq", 32'(rd_err), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("err_cleared", 32'(rd_err), 0);
`endif

        run_event(2'd2, 12'h010, 12'h013, 4, 1'b0, 1'b0);
        // Back-to-back: next header issued in the rd_done cycle.
        run_event(2'd1, 12'hFFE, 12'h001, 4, 1'b0, 1'b1);
`ifdef WVB_RD_ADDR_OVERRUN_CHK_EN
        check("err_hdr_in_read", 32'(rd_err), 1);
`endif
        run_event(2'd3, 12'h100, 12'h0FF, 4096, 1'b0, 1'b0);
        run_event(2'd0, 12'h020, 12'h030, 3, 1'b1, 1'b0);
        run_event(2'd3, 12'h055, 12'h055, 1, 1'b0, 1'b0);

        // Reset in the middle of an event.
        start_header(2'd1, 12'h200, 12'h2FF);
        wvb_rdreq = 1'b1;
        begin
            exp_t e;
            e.addr = 12'h200;
            e.last = 1'b0;
            e.wl   = 13'd256;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        wvb_rdreq = 1'b0;
        check("mid_addr", 32'(wvb_rd_addr), 32'h201);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state();

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
